pc_next_unit: RTL and testbench

Parametrised next-PC and ALUOut stage for the multicycle MIPS datapath. Replaces the single 2:1 ALU-output select with:
- a registered ALUOut,
- a 4-way PC source select (including jump and exception vector),
- conditional branch write for beq/bne,
- misaligned-target trapping with an EPC capture register.

It sits between the ALU and the PC register, and is driven by the main control FSM.

---
 rtl/pc_next_unit.sv | 99 +++++++++
 tb/tb_pc_next_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Next-PC select, ALUOut register, conditional branch write and misaligned-target
// trap with EPC capture for the multicycle MIPS datapath.
module pc_next_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_out_en,
  input  logic [1:0]       pc_src,
  input  logic [25:0]      jump_index,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic             branch_ne,
  input  logic             zero,
  input  logic             exception,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] epc,
  output logic             addr_err
);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] alu_out_r;
  logic [WIDTH-1:0] epc_r;
  logic             addr_err_r;
  logic [WIDTH-1:0] pc_next_s;
  logic             take_s;
  logic             misalign_s;

  // Target select; pc_src=1 deliberately sees the registered (old) ALUOut.
  always_comb begin
    pc_next_s = alu_result;
    case (pc_src)
      2'd0:    pc_next_s = alu_result;
      2'd1:    pc_next_s = alu_out_r;
      2'd2:    pc_next_s = {pc_r[WIDTH-1:28], jump_index, 2'b00};
      2'd3:    pc_next_s = EXC_VECTOR;
      default: pc_next_s = alu_result;
    endcase
  end

  // Write decision; the exception vector itself is never treated as misaligned.
  always_comb begin
    take_s     = pc_write | (pc_write_cond & (zero ^ branch_ne));
    misalign_s = 1'b0;
    if (take_s && (pc_next_s[1:0] != 2'b00) && (pc_src != 2'd3)) begin
      misalign_s = 1'b1;
    end else begin
      misalign_s = 1'b0;
    end
  end

  // ALUOut capture, independent of the PC path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_r <= {WIDTH{1'b0}};
    end else if (alu_out_en) begin
      alu_out_r <= alu_result;
    end else begin
      alu_out_r <= alu_out_r;
    end
  end

  // PC / EPC / trap pulse with exception > misalign > take priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      epc_r      <= {WIDTH{1'b0}};
      addr_err_r <= 1'b0;
    end else if (exception) begin
      pc_r       <= EXC_VECTOR;
      epc_r      <= pc_r;
      addr_err_r <= 1'b0;
    end else if (misalign_s) begin
      pc_r       <= EXC_VECTOR;
      epc_r      <= pc_next_s;
      addr_err_r <= 1'b1;
    end else if (take_s) begin
      pc_r       <= pc_next_s;
      epc_r      <= epc_r;
      addr_err_r <= 1'b0;
    end else begin
      pc_r       <= pc_r;
      epc_r      <= epc_r;
      addr_err_r <= 1'b0;
    end
  end

  assign pc       = pc_r;
  assign alu_out  = alu_out_r;
  assign pc_next  = pc_next_s;
  assign epc      = epc_r;
  assign addr_err = addr_err_r;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed and randomized bench for pc_next_unit against a behavioural model.
module tb_pc_next_unit;

  localparam logic [31:0] EXC = 32'h8000_0180;
  localparam logic [31:0] RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_result;
  logic        alu_out_en;
  logic [1:0]  pc_src;
  logic [25:0] jump_index;
  logic        pc_write;
  logic        pc_write_cond;
  logic        branch_ne;
  logic        zero;
  logic        exception;
  logic [31:0] pc;
  logic [31:0] alu_out;
  logic [31:0] pc_next;
  logic [31:0] epc;
  logic        addr_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_alu_out, m_epc;
  logic        m_err;

  pc_next_unit dut (
    .clk(clk), .rst_n(rst_n), .alu_result(alu_result), .alu_out_en(alu_out_en),
    .pc_src(pc_src), .jump_index(jump_index), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .zero(zero),
    .exception(exception), .pc(pc), .alu_out(alu_out), .pc_next(pc_next),
    .epc(epc), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Target the spec describes, computed arithmetically from the model state.
  function automatic logic [31:0] model_target();
    case (pc_src)
      2'd0:    return alu_result;
      2'd1:    return m_alu_out;
      2'd2:    return (m_pc & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4);
      default: return EXC;
    endcase
  endfunction

  task automatic idle();
    alu_out_en = 1'b0; pc_src = 2'd0; jump_index = 26'd0; pc_write = 1'b0;
    pc_write_cond = 1'b0; branch_ne = 1'b0; zero = 1'b0; exception = 1'b0;
    alu_result = 32'd0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ":pc"}, pc, m_pc);
    chk({tag, ":alu_out"}, alu_out, m_alu_out);
    chk({tag, ":epc"}, epc, m_epc);
    chk({tag, ":addr_err"}, {31'd0, addr_err}, {31'd0, m_err});
  endtask

  // One clock: check the combinational target, advance the model, check registers.
  task automatic step(input string tag);
    logic [31:0] tgt;
    logic        take, mis;
    #1;
    tgt  = model_target();
    chk({tag, ":pc_next"}, pc_next, tgt);
    take = pc_write || (pc_write_cond && (branch_ne ? !zero : zero));
    mis  = take && (tgt % 4 != 0) && (pc_src != 2'd3);
    @(posedge clk);
    if (exception) begin
      m_epc = m_pc; m_pc = EXC; m_err = 1'b0;
    end else if (mis) begin
      m_epc = tgt; m_pc = EXC; m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      if (take) m_pc = tgt;
    end
    if (alu_out_en) m_alu_out = alu_result;
    #1;
    check_regs(tag);
  endtask

  task automatic load_pc(input logic [31:0] v);
    idle(); alu_result = v; pc_write = 1'b1;
    step("load_pc");
    chk("load_pc_const", pc, v);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    m_pc = RST; m_alu_out = 32'd0; m_epc = 32'd0; m_err = 1'b0;
    #3;
    check_regs("reset_init");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // sequential fetch
    for (int i = 1; i <= 3; i++) begin
      idle(); alu_result = 32'(i * 4); pc_write = 1'b1;
      step("fetch");
      chk("fetch_const", pc, 32'(i * 4));
    end
    idle();
    step("fetch_hold");
    chk("fetch_hold_const", pc, 32'd12);

    // branches
    idle(); alu_out_en = 1'b1; alu_result = 32'h40;
    step("br_load");
    idle(); pc_src = 2'd1; pc_write_cond = 1'b1; zero = 1'b1;
    step("beq_taken");
    chk("beq_taken_const", pc, 32'h40);
    load_pc(32'h10);
    idle(); pc_src = 2'd1; pc_write_cond = 1'b1; zero = 1'b0;
    step("beq_not");
    chk("beq_not_const", pc, 32'h10);
    idle(); pc_src = 2'd1; pc_write_cond = 1'b1; branch_ne = 1'b1; zero = 1'b0;
    step("bne_taken");
    chk("bne_taken_const", pc, 32'h40);
    idle(); pc_src = 2'd0; alu_result = 32'h88; pc_write = 1'b1; pc_write_cond = 1'b1; zero = 1'b0;
    step("both_writes");
    chk("both_writes_const", pc, 32'h88);

    // jump
    load_pc(32'h1000_0004);
    idle(); pc_src = 2'd2; jump_index = 26'h00_0100; pc_write = 1'b1;
    step("jump");
    chk("jump_const", pc, 32'h1000_0400);

    // misaligned trap, then the pulse must drop
    load_pc(32'h20);
    idle(); alu_result = 32'h22; pc_write = 1'b1;
    step("misalign");
    chk("misalign_pc", pc, EXC);
    chk("misalign_epc", epc, 32'h22);
    chk("misalign_err", {31'd0, addr_err}, 32'd1);
    idle();
    step("misalign_drop");
    chk("misalign_drop_err", {31'd0, addr_err}, 32'd0);

    // exception beats misalign
    load_pc(32'h30);
    idle(); exception = 1'b1; alu_result = 32'h32; pc_write = 1'b1;
    step("exc_prio");
    chk("exc_prio_pc", pc, EXC);
    chk("exc_prio_epc", epc, 32'h30);
    chk("exc_prio_err", {31'd0, addr_err}, 32'd0);

    // same-cycle ALUOut capture and pc_src=1 uses the old value
    idle(); alu_out_en = 1'b1; alu_result = 32'h100;
    step("aluout_a");
    idle(); alu_out_en = 1'b1; alu_result = 32'h200; pc_src = 2'd1; pc_write = 1'b1;
    step("aluout_old");
    chk("aluout_old_pc", pc, 32'h100);
    chk("aluout_old_reg", alu_out, 32'h200);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      alu_out_en    = 1'($urandom_range(0, 1));
      pc_src        = 2'($urandom_range(0, 3));
      jump_index    = 26'($urandom);
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = 1'($urandom_range(0, 1));
      branch_ne     = 1'($urandom_range(0, 1));
      zero          = 1'($urandom_range(0, 1));
      exception     = ($urandom_range(0, 15) == 0);
      alu_result    = $urandom;
      if ($urandom_range(0, 3) != 0) alu_result[1:0] = 2'b00;
      step("random");
    end

    // asynchronous reset mid-cycle with a pending write
    idle(); alu_result = 32'h44; pc_write = 1'b1; alu_out_en = 1'b1;
    #2;
    rst_n = 1'b0;
    m_pc = RST; m_alu_out = 32'd0; m_epc = 32'd0; m_err = 1'b0;
    #1;
    check_regs("reset_async");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_regs("reset_hold");
    end
    @(negedge clk); rst_n = 1'b1;
    idle(); alu_result = 32'h44; pc_write = 1'b1;
    step("after_reset");
    chk("after_reset_const", pc, 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
